// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: shared definitions for the registered MIPS ALU with iterative
// multiply/divide. Holds the op-code encodings, the control FSM state type and
// helpers for sizing the iteration counter and classifying op codes.
package mips_alu_pkg;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SLTU  = 4'b0011;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_MULT  = 4'b1000;
   localparam logic [3:0] OP_MULTU = 4'b1001;
   localparam logic [3:0] OP_DIV   = 4'b1010;
   localparam logic [3:0] OP_DIVU  = 4'b1011;
   localparam logic [3:0] OP_NOR   = 4'b1100;
   localparam logic [3:0] OP_MFHI  = 4'b1101;
   localparam logic [3:0] OP_MFLO  = 4'b1110;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   // Counter must be able to hold WIDTH itself (the "finished" value).
   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

   // Multi-cycle ops occupy codes 10xx; bit 1 selects divide, bit 0 unsigned.
   function automatic logic is_md(input logic [3:0] op);
      return op[3:2] == 2'b10;
   endfunction

endpackage

// File: rtl/mips_md_iter.sv
// mips_md_iter: iterative multiply/divide datapath on unsigned magnitudes.
// One step per cycle while run is high, WIDTH steps in total.
//   load   : capture ma/mb/is_div and clear the counter
//   run    : perform one step (ignored once cnt == WIDTH)
//   p_hi   : multiply upper product half / divide remainder
//   p_lo   : multiply lower product half / divide quotient
//   cnt    : completed step count
//   last   : the step being done this cycle is the final one
module mips_md_iter import mips_alu_pkg::*; #(
   parameter int WIDTH = 32,
   parameter int CW    = cnt_w(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             run,
   input  logic             is_div,
   input  logic [WIDTH-1:0] ma,
   input  logic [WIDTH-1:0] mb,
   output logic [WIDTH-1:0] p_hi,
   output logic [WIDTH-1:0] p_lo,
   output logic [CW-1:0]    cnt,
   output logic             last
);

   logic [WIDTH-1:0] d;
   logic             div_q;
   logic [WIDTH:0]   msum, rsh, rsub;
   logic             ge;

   always_comb begin
      // Shift-add: add multiplicand into the upper half when the current
      // multiplier bit (p_lo[0]) is set; the carry shifts down next.
      msum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, d} : '0);
      // Restoring divide: bring the next dividend bit into the remainder.
      rsh  = {p_hi, p_lo[WIDTH-1]};
      rsub = rsh - {1'b0, d};
      ge   = rsh >= {1'b0, d};
      last = run && (cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         d     <= '0;
         div_q <= 1'b0;
         p_hi  <= '0;
         p_lo  <= '0;
         cnt   <= '0;
      end else if (load) begin
         d     <= mb;
         div_q <= is_div;
         p_hi  <= '0;
         p_lo  <= ma;
         cnt   <= '0;
      end else if (run && cnt != CW'(WIDTH)) begin
         if (div_q) begin
            p_hi <= ge ? rsub[WIDTH-1:0] : rsh[WIDTH-1:0];
            p_lo <= {p_lo[WIDTH-2:0], ge};
         end else begin
            p_hi <= msum[WIDTH:1];
            p_lo <= {msum[0], p_lo[WIDTH-1:1]};
         end
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mips_alu_md.sv
// mips_alu_md: registered EX-stage ALU with start/done handshake, single-cycle
// logic/arith/compare ops, iterative MULT/MULTU/DIV/DIVU and HI/LO registers.
//   start/op/a/b : request, accepted when start && !busy
//   busy         : multi-cycle op in progress
//   done         : one-cycle pulse, result/zero/overflow (hi/lo for mul/div) valid
//   result/zero  : registered result and its zero flag
//   overflow     : signed overflow of ADD/SUB
//   div_zero     : divide by zero, valid with done
//   hi/lo        : architectural HI/LO
module mips_alu_md import mips_alu_pkg::*; #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = cnt_w(WIDTH);

   state_t           state;
   logic [3:0]       op_q;
   logic             sa_q, sb_q, bz_q;
   logic [WIDTH-1:0] a_q;

   logic             accept, load, is_sgn, sa, sb, last;
   logic [WIDTH-1:0] ma, mb, p_hi, p_lo, sum, diff, alu_res, hi_n, lo_n;
   logic             alu_ovf;
   logic [2*WIDTH-1:0] prod, sprod;
   logic [CW-1:0]    cnt;

   assign busy   = (state != S_IDLE);
   assign accept = start && (state == S_IDLE);
   assign load   = accept && is_md(op);

   // Signed ops work on magnitudes; -2^(WIDTH-1) negates to itself, which is
   // still the correct unsigned magnitude.
   always_comb begin
      is_sgn = (op == OP_MULT) || (op == OP_DIV);
      sa     = is_sgn && a[WIDTH-1];
      sb     = is_sgn && b[WIDTH-1];
      ma     = sa ? -a : a;
      mb     = sb ? -b : b;
   end

   mips_md_iter #(.WIDTH(WIDTH), .CW(CW)) u_iter (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .run    (state == S_RUN),
      .is_div (op[1]),
      .ma     (ma),
      .mb     (mb),
      .p_hi   (p_hi),
      .p_lo   (p_lo),
      .cnt    (cnt),
      .last   (last)
   );

   always_comb begin
      sum     = a + b;
      diff    = a - b;
      alu_res = '0;
      alu_ovf = 1'b0;
      case (op)
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_NOR:  alu_res = ~(a | b);
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT:  alu_res[0] = $signed(a) < $signed(b);
         OP_SLTU: alu_res[0] = a < b;
         OP_MFHI: alu_res = hi;
         OP_MFLO: alu_res = lo;
         default: alu_res = '0;
      endcase
   end

   // Sign correction: product negated when signs differ; quotient likewise,
   // remainder follows the dividend.
   always_comb begin
      prod  = {p_hi, p_lo};
      sprod = (sa_q ^ sb_q) ? -prod : prod;
      if (!op_q[1]) begin
         hi_n = sprod[2*WIDTH-1:WIDTH];
         lo_n = sprod[WIDTH-1:0];
      end else if (bz_q) begin
         hi_n = a_q;
         lo_n = '1;
      end else begin
         hi_n = sa_q ? -p_hi : p_hi;
         lo_n = (sa_q ^ sb_q) ? -p_lo : p_lo;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         op_q     <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         bz_q     <= 1'b0;
         a_q      <= '0;
         done     <= 1'b0;
         result   <= '0;
         zero     <= 1'b0;
         overflow <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         case (state)
            S_IDLE: if (accept) begin
               if (is_md(op)) begin
                  op_q  <= op;
                  sa_q  <= sa;
                  sb_q  <= sb;
                  bz_q  <= (b == '0);
                  a_q   <= a;
                  state <= S_RUN;
               end else begin
                  result   <= alu_res;
                  zero     <= (alu_res == '0);
                  overflow <= alu_ovf;
                  done     <= 1'b1;
               end
            end
            S_RUN: if (last) state <= S_FIX;
            S_FIX: begin
               // Counter must have completed; anything else is an aborted op.
               if (cnt == CW'(WIDTH)) begin
                  hi       <= hi_n;
                  lo       <= lo_n;
                  result   <= lo_n;
                  zero     <= (lo_n == '0);
                  overflow <= 1'b0;
                  div_zero <= op_q[1] && bz_q;
                  done     <= 1'b1;
               end
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_alu_md.sv
module tb_mips_alu_md;

   logic        clk, reset;
   logic        start, busy, done, zero, overflow, div_zero;
   logic [3:0]  op;
   logic [31:0] a, b, result, hi, lo;

   logic        start8, busy8, done8, zero8, overflow8, div_zero8;
   logic [3:0]  op8;
   logic [7:0]  a8, b8, result8, hi8, lo8;

   int checks = 0;
   int errors = 0;

   mips_alu_md #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .zero(zero),
      .overflow(overflow), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   mips_alu_md #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .result(result8), .zero(zero8),
      .overflow(overflow8), .div_zero(div_zero8), .hi(hi8), .lo(lo8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive a request for one edge; returns #1 after the accept edge (cycle 1).
   task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Step until done (bounded), counting cycles where busy was low meanwhile.
   task automatic wait_done(input int c0, output int cyc, output int blo);
      cyc = c0; blo = 0;
      while (!done && cyc < 80) begin
         if (!busy) blo++;
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, result, zero, overflow, div_zero, hi, lo} !== '0) begin
         errors++; $display("FAIL reset32 got busy=%b done=%b res=%h hi=%h lo=%h want all 0", busy, done, result, hi, lo);
      end
      checks++;
      if ({busy8, done8, result8, zero8, overflow8, div_zero8, hi8, lo8} !== '0) begin
         errors++; $display("FAIL reset8 got res=%h hi=%h lo=%h want all 0", result8, hi8, lo8);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_add_sub();
      issue(4'b0010, 32'h7FFF_FFFF, 32'h1);
      checks++;
      if ({done, busy, result, overflow} !== {1'b1, 1'b0, 32'h8000_0000, 1'b1}) begin
         errors++; $display("FAIL add_ovf got done=%b busy=%b res=%h ovf=%b want 1 0 80000000 1", done, busy, result, overflow);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL add_single_done got %b want 0", done);
      end
      issue(4'b0110, 32'd5, 32'd5);
      checks++;
      if ({done, result, zero, overflow} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
         errors++; $display("FAIL sub_zero got done=%b res=%h zero=%b ovf=%b want 1 0 1 0", done, result, zero, overflow);
      end
      issue(4'b0110, 32'h8000_0000, 32'h1);
      checks++;
      if ({result, zero, overflow} !== {32'h7FFF_FFFF, 1'b0, 1'b1}) begin
         errors++; $display("FAIL sub_ovf got res=%h zero=%b ovf=%b want 7fffffff 0 1", result, zero, overflow);
      end
   endtask

   task automatic test_logic_cmp();
      issue(4'b0111, 32'hFFFF_FFFF, 32'h1);
      checks++;
      if ({done, result} !== {1'b1, 32'h1}) begin
         errors++; $display("FAIL slt got done=%b res=%h want 1 00000001", done, result);
      end
      issue(4'b0011, 32'hFFFF_FFFF, 32'h1);
      checks++;
      if ({result, zero} !== {32'h0, 1'b1}) begin
         errors++; $display("FAIL sltu got res=%h zero=%b want 00000000 1", result, zero);
      end
      issue(4'b1100, 32'h0, 32'h0);
      checks++;
      if (result !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL nor got %h want ffffffff", result);
      end
      issue(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00);
      checks++;
      if (result !== 32'h00F0_1200) begin
         errors++; $display("FAIL and got %h want 00f01200", result);
      end
      issue(4'b1111, 32'h1234, 32'h5678);
      checks++;
      if ({done, result, zero} !== {1'b1, 32'h0, 1'b1}) begin
         errors++; $display("FAIL undef_op got done=%b res=%h want 1 0", done, result);
      end
   endtask

   task automatic test_mult();
      int cyc, blo;
      issue(4'b1000, 32'hFFFF_FFFD, 32'd7);
      wait_done(1, cyc, blo);
      checks++;
      if (cyc !== 34 || blo !== 0 || busy !== 1'b0) begin
         errors++; $display("FAIL mult_timing got done@%0d busy_low=%0d busy=%b want 34 0 0", cyc, blo, busy);
      end
      checks++;
      if ({hi, lo, result, overflow} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'hFFFF_FFEB, 1'b0}) begin
         errors++; $display("FAIL mult got hi=%h lo=%h res=%h ovf=%b want ffffffff ffffffeb ffffffeb 0", hi, lo, result, overflow);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL mult_done_pulse got %b want 0", done);
      end
      issue(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(1, cyc, blo);
      checks++;
      if ({hi, lo} !== {32'hFFFF_FFFE, 32'h1} || cyc !== 34) begin
         errors++; $display("FAIL multu got hi=%h lo=%h done@%0d want fffffffe 00000001 34", hi, lo, cyc);
      end
   endtask

   task automatic test_div();
      int cyc, blo;
      issue(4'b1010, 32'hFFFF_FFF9, 32'd2);
      wait_done(1, cyc, blo);
      checks++;
      if ({lo, hi, div_zero} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0}) begin
         errors++; $display("FAIL div got lo=%h hi=%h dz=%b want fffffffd ffffffff 0", lo, hi, div_zero);
      end
      issue(4'b1011, 32'd7, 32'd0);
      wait_done(1, cyc, blo);
      checks++;
      if ({lo, hi, div_zero, result} !== {32'hFFFF_FFFF, 32'd7, 1'b1, 32'hFFFF_FFFF} || cyc !== 34) begin
         errors++; $display("FAIL divu_zero got lo=%h hi=%h dz=%b res=%h done@%0d want ffffffff 7 1 ffffffff 34", lo, hi, div_zero, result, cyc);
      end
      issue(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(1, cyc, blo);
      checks++;
      if ({lo, hi, div_zero} !== {32'h8000_0000, 32'h0, 1'b0}) begin
         errors++; $display("FAIL div_minint got lo=%h hi=%h dz=%b want 80000000 0 0", lo, hi, div_zero);
      end
      issue(4'b1011, 32'd100, 32'd7);
      wait_done(1, cyc, blo);
      checks++;
      if ({lo, hi} !== {32'd14, 32'd2}) begin
         errors++; $display("FAIL divu got lo=%h hi=%h want 0000000e 00000002", lo, hi);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, blo;
      issue(4'b1000, 32'd6, 32'd7);
      repeat (3) begin @(posedge clk); #1; end
      // cycle 4: pulse an ADD that must be ignored
      start = 1'b1; op = 4'b0010; a = 32'd1; b = 32'd1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if ({done, busy} !== 2'b01) begin
         errors++; $display("FAIL ignore_start got done=%b busy=%b want 0 1", done, busy);
      end
      wait_done(5, cyc, blo);
      checks++;
      if (cyc !== 34 || {lo, result} !== {32'd42, 32'd42}) begin
         errors++; $display("FAIL mult_after_ignore got done@%0d lo=%h res=%h want 34 2a 2a", cyc, lo, result);
      end
      // MFLO issued in the done cycle
      start = 1'b1; op = 4'b1110; a = 32'h0; b = 32'h0;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if ({done, result} !== {1'b1, 32'd42}) begin
         errors++; $display("FAIL mflo_b2b got done=%b res=%h want 1 0000002a", done, result);
      end
      issue(4'b1101, 32'h0, 32'h0);
      checks++;
      if ({result, zero} !== {32'h0, 1'b1}) begin
         errors++; $display("FAIL mfhi got res=%h zero=%b want 0 1", result, zero);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      issue(4'b1010, 32'd100, 32'd3);
      repeat (9) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if ({busy, done, result, zero, overflow, div_zero, hi, lo} !== '0) begin
         errors++; $display("FAIL reset_mid got busy=%b done=%b res=%h hi=%h lo=%h want all 0", busy, done, result, hi, lo);
      end
      n = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done || busy) n++;
      end
      checks++;
      if (n !== 0) begin
         errors++; $display("FAIL reset_mid_no_done got %0d active cycles want 0", n);
      end
   endtask

   task automatic test_w8();
      int cyc, blo;
      @(negedge clk);
      start8 = 1'b1; op8 = 4'b1000; a8 = 8'h80; b8 = 8'hFF;
      @(posedge clk); #1;
      start8 = 1'b0;
      cyc = 1; blo = 0;
      while (!done8 && cyc < 40) begin
         if (!busy8) blo++;
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if (cyc !== 10 || blo !== 0 || busy8 !== 1'b0) begin
         errors++; $display("FAIL w8_timing got done@%0d busy_low=%0d want 10 0", cyc, blo);
      end
      checks++;
      if ({hi8, lo8, result8} !== {8'h00, 8'h80, 8'h80}) begin
         errors++; $display("FAIL w8_mult got hi=%h lo=%h res=%h want 00 80 80", hi8, lo8, result8);
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0; op = '0; a = '0; b = '0;
      start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
      test_reset();
      test_add_sub();
      test_logic_cmp();
      test_mult();
      test_div();
      test_back_to_back();
      test_reset_mid();
      test_w8();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_alu_md.md
# mips_alu_md

Parametrised successor to the datapath ALU: a registered ALU with a start/done handshake that adds signed/unsigned iterative multiply and divide, HI/LO registers, NOR, unsigned set-less-than and a signed-overflow flag. It sits in the EX stage; the control unit drives `start` with the decoded op and stalls on `busy` while a multi-cycle op runs.

## Interface
- `WIDTH`, 32, operand/result width; even, ≥ 4
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request; accepted on an edge where `start && !busy`
- `op`  in  4  operation code, sampled at accept
- `a`, `b`  in  WIDTH each  operands, sampled at accept
- `busy`  out  1  multi-cycle op in progress
- `done`  out  1  one-cycle pulse: `result`/`zero`/`overflow` (and `hi`/`lo` for mul/div) are valid
- `result`  out  WIDTH  registered result, held until next `done`
- `zero`  out  1  `result == 0`, registered with `result`
- `overflow`  out  1  signed overflow of ADD/SUB, else 0
- `div_zero`  out  1  high with `done` when DIV/DIVU had `b == 0`
- `hi`, `lo`  out  WIDTH each  architectural HI/LO registers

## Operation
- Op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 0011 SLTU, 1100 NOR, 1101 MFHI, 1110 MFLO, 1000 MULT, 1001 MULTU, 1010 DIV, 1011 DIVU; any other code → `result` 0, `done` pulses.
- ADD/SUB wrap modulo 2^WIDTH; `overflow` = operand signs match (ADD) or differ (SUB) and result sign differs from `a`.
- SLT/SLTU: `result` = 1 or 0, zero-extended.
- MULT/MULTU: full 2·WIDTH product; `hi` = upper half, `lo` = lower half.
- DIV/DIVU: `lo` = quotient truncated toward zero, `hi` = remainder carrying the dividend's sign.
- Divide by zero: `lo` = all ones, `hi` = `a`, `div_zero` = 1; latency unchanged.
- Signed `-2^(WIDTH-1) / -1`: `lo` = `-2^(WIDTH-1)`, `hi` = 0; no flag.
- On mul/div completion `result` = new `lo`; `overflow` = 0.
- FSM states: IDLE → (mul/div accepted) RUN → (iteration counter reaches WIDTH) FIX → IDLE.
- Accept: latch operand magnitudes and sign flags (signed ops only), then clear the counter.
- RUN: one shift-add or restoring-subtract step per cycle.
- FIX: apply sign correction, write `hi`/`lo`/`result`, pulse `done`.
- `start` while `busy` is ignored; no queuing.

## Timing
- Reset: `busy`, `done`, `result`, `zero`, `overflow`, `div_zero`, `hi`, `lo` = 0; state IDLE.
- Single-cycle ops: accepted at edge E0; `done` = 1 with valid outputs in the cycle after E0; `busy` stays 0.
- Mul/div: `busy` = 1 from the cycle after accept until FIX completes; `done` = 1 exactly WIDTH+2 cycles after accept, in a cycle where `busy` = 0.
- Back-to-back: a new `start` is accepted in the `done` cycle.
- MFHI/MFLO accepted in the `done` cycle of a mul/div see the updated `hi`/`lo`.
- Reset mid-operation: abort next edge, no `done`, `hi`/`lo` cleared.
- `done` is never asserted for two consecutive cycles from the same request.

## Structure
- Package `mips_alu_pkg`: op-code localparams, FSM state enum, `WIDTH`-derived counter width (`$clog2(WIDTH+1)`).
- Sub-module `mips_md_iter`: iterative multiply/divide datapath (magnitudes in; partial product/remainder registers, counter and `last` flag out).
- Top: handshake, FSM, single-cycle ops, sign correction and output registers.

## Test plan
- ADD 0x7FFFFFFF + 1 → `result` 0x80000000, `overflow` 1, `done` one cycle after accept; SUB 5 − 5 → `result` 0, `zero` 1.
- SLT a=0xFFFFFFFF b=1 → 1; SLTU same operands → 0; NOR 0 0 → 0xFFFFFFFF.
- MULT −3 × 7 → `hi` 0xFFFFFFFF, `lo` 0xFFFFFFEB, `done` at cycle 34, `busy` high cycles 1–33; MULTU 0xFFFFFFFF² → `hi` 0xFFFFFFFE, `lo` 1.
- DIV −7 / 2 → `lo` 0xFFFFFFFD, `hi` 0xFFFFFFFF; DIVU 7 / 0 → `lo` 0xFFFFFFFF, `hi` 7, `div_zero` 1.
- `start` pulsed mid-MULT → ignored; MFLO issued in the `done` cycle → returns the new `lo` one cycle later.
- `reset` asserted at cycle 10 of a DIV → no `done`, all outputs 0; WIDTH=8 instance: MULT −128 × −1 → `hi` 0x00, `lo` 0x80, `done` at cycle 10.
